accel_share_arbiter: RTL
========================

// Module: accel_share_arbiter
// PURPOSE
//  Shares one crypto accelerator (AES0/SHA256/RSA wrapper class) among NUM_REQ requesters.
//  - Round-robin grant, exclusive ownership, and start/done sequencing.
//  - Busy-phase watchdog that aborts a hung accelerator.
//  - Access-control mask (from acct) and debug-mode freeze of new grants.
//  - Sits between the requester side (core/DMA/JTAG agents) and the accelerator wrapper.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  TIMEOUT_CYC  1024  max BUSY cycles before abort (>=2)
//  CNT_W        11    watchdog counter width; must hold TIMEOUT_CYC
// PORTS
//  clk_i          in   1        clock
//  rst_ni         in   1        async active-low reset
//  req_i          in   NUM_REQ  level request; held for the whole ownership
//  start_i        in   NUM_REQ  start pulse from requester; honoured only for the owner in GRANT
//  req_mask_i     in   NUM_REQ  1 = requester permitted (acc_ctrl derived)
//  debug_mode_i   in   1        1 = no new grants issued
//  accel_done_i   in   1        accelerator completion pulse
//  gnt_o          out  NUM_REQ  one-hot (or zero) grant, registered
//  owner_o        out  3        index of current owner (valid when |gnt_o)
//  accel_start_o  out  1        1-cycle start to accelerator
//  accel_abort_o  out  1        1-cycle abort to accelerator on timeout
//  busy_o         out  1        1 while in BUSY
//  timeout_o      out  1        1-cycle timeout flag, coincident with accel_abort_o
// BEHAVIOUR
//  Reset (async, rst_ni=0):
//   - all outputs 0; state=IDLE; counter=0; last_owner=NUM_REQ-1, so req 0 has top priority first.
//  Eligibility: elig = req_i & req_mask_i.
//  States:
//   - IDLE: if elig!=0 and debug_mode_i=0, pick the first set bit scanning from
//     (last_owner+1) mod NUM_REQ upward with wrap. Latch owner; last_owner=owner; go to GRANT.
//     gnt_o is asserted the cycle after the request is sampled (1-cycle latency).
//   - GRANT: gnt_o[owner]=1.
//     - req_i[owner]=0 or req_mask_i[owner]=0 -> IDLE, grant dropped next cycle.
//       There is always >=1 IDLE cycle between owners.
//     - else if start_i[owner]=1 -> accel_start_o=1 for exactly that cycle (combinational
//       from registered state); go to BUSY; counter cleared to 0.
//     - start_i from non-owners is ignored in every state.
//   - BUSY: gnt_o[owner] stays 1; busy_o=1; counter increments every cycle.
//     - accel_done_i=1 -> GRANT, same owner; owner may issue another start.
//     - else if counter==TIMEOUT_CYC-1 -> accel_abort_o=1 and timeout_o=1 for 1 cycle;
//       go to IDLE; grant revoked.
//     - Simultaneous done and timeout: done wins; no abort.
//     - req drop or mask drop in BUSY: BUSY continues to done/timeout, then goes to GRANT,
//       which releases the owner if the condition still holds.
//     - debug_mode_i has no effect on an existing owner; it blocks only the IDLE->GRANT move.
//     - accel_done_i outside BUSY is ignored.
//  Round-robin: last_owner updates only on grant.
//   - A requester that re-asserts immediately after release loses to any other eligible requester.
//  Invariants: gnt_o one-hot or zero; at most one of accel_start_o/accel_abort_o per cycle;
//   busy_o implies |gnt_o.
//  Reset mid-BUSY: outputs drop asynchronously; no abort pulse is issued; the accelerator
//   shares rst_ni.
// TESTING
//  1. Reset; req_i=4'b0101, mask=4'hF -> gnt_o=0001 one cycle later; drop req0 -> gnt 0000, then 0100.
//  2. req_i=4'b1111 held; each owner drops req after 1 start/done -> grant order 0,1,2,3,0.
//  3. Owner 2 starts; accel_done_i pulses after 10 cycles -> busy_o high 10 cycles, back to GRANT,
//     gnt_o=0100 kept.
//  4. TIMEOUT_CYC=8, owner 1 starts, no done -> accel_abort_o and timeout_o pulse 8 cycles after
//     start; gnt_o=0.
//  5. debug_mode_i=1 with req_i=0001 -> no grant; clear debug -> gnt_o=0001 next cycle.
//     mask[0]=0 in GRANT -> revoked.
//  6. Done and timeout in same cycle -> no abort, GRANT.
//     rst_ni low during BUSY -> all outputs 0 immediately; req0 wins first after release.

Source files
------------

// File: rtl/accel_share_arbiter_if.sv
// Requester-side and accelerator-side signals of the shared-accelerator arbiter.
// The arbiter uses the slave modport; the requester/accelerator side uses master.
interface accel_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] start_i;
    logic [NUM_REQ-1:0] req_mask_i;
    logic               debug_mode_i;
    logic               accel_done_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [2:0]         owner_o;
    logic               accel_start_o;
    logic               accel_abort_o;
    logic               busy_o;
    logic               timeout_o;

    modport master (
        output req_i, start_i, req_mask_i, debug_mode_i, accel_done_i,
        input  gnt_o, owner_o, accel_start_o, accel_abort_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, start_i, req_mask_i, debug_mode_i, accel_done_i,
        output gnt_o, owner_o, accel_start_o, accel_abort_o, busy_o, timeout_o
    );
endinterface

// File: rtl/accel_share_arbiter.sv
// Round-robin owner arbitration for one shared crypto accelerator, with start/done
// sequencing, a busy-phase watchdog, access mask and debug freeze of new grants.
module accel_share_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    accel_share_arbiter_if.slave  bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] elig;
    logic               owner_ok;
    logic               owner_start;
    logic               cnt_hit;
    logic               pick_vld;
    logic [IdxW-1:0]    pick_idx;

    assign elig        = bus.req_i & bus.req_mask_i;
    assign owner_ok    = bus.req_i[owner_q] & bus.req_mask_i[owner_q];
    assign owner_start = owner_ok & bus.start_i[owner_q];
    assign cnt_hit     = (cnt_q == CntLast);

    // First eligible requester after last_q, wrapping.
    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cidx;
        cand     = 0;
        cidx     = '0;
        pick_vld = 1'b0;
        pick_idx = last_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_q) + i) % NUM_REQ;
            cidx = IdxW'(cand);
            if (!pick_vld && elig[cidx]) begin
                pick_vld = 1'b1;
                pick_idx = cidx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                if (pick_vld && !bus.debug_mode_i) begin
                    state_d         = StGrant;
                    owner_d         = pick_idx;
                    last_d          = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                end
            end
            StGrant: begin
                if (!owner_ok) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else if (owner_start) begin
                    state_d = StBusy;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Done takes precedence over a coincident watchdog expiry.
                if (bus.accel_done_i) begin
                    state_d = StGrant;
                    busy_d  = 1'b0;
                end else if (cnt_hit) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdxW'(NUM_REQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt_o         = gnt_q;
    assign bus.owner_o       = 3'(owner_q);
    assign bus.busy_o        = busy_q;
    assign bus.accel_start_o = (state_q == StGrant) & owner_start;
    assign bus.accel_abort_o = (state_q == StBusy) & cnt_hit & ~bus.accel_done_i;
    assign bus.timeout_o     = bus.accel_abort_o;
endmodule
